sobel_morph_filter: RTL and testbench

- Downstream stage of the Sobel edge detector. Consumes its 1-bit edge stream and the matching write enable (0 = edge/black, 1 = background/white).
- Applies a 3x3 binary morphological operation: erosion thickens black edges, dilation thins them.
- Uses its own 1-bit line buffers.
- Output feeds the RGB565 frame-buffer write path: 16-bit pixel, 1-bit copy and write enable.

---
 rtl/sobel_morph_filter.sv | 139 +++++++++++++
 tb/tb_sobel_morph_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_morph_filter.sv
// 3x3 binary morphology (erosion/dilation) on the Sobel edge stream.
// Produces an RGB565-ready pixel, its 1-bit copy and a write enable two cycles
// after each input beat. Windows that reach outside the frame are forced to BORDER_VAL.
// Optional macro MORPH_FRAME_SYNC_EN adds a frame_start input that realigns the
// row/column counters to (0,0).
module sobel_morph_filter #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter bit          MODE       = 1'b0,
    parameter bit          BORDER_VAL = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wr_en,
    input  logic        bin_in,
`ifdef MORPH_FRAME_SYNC_EN
    input  logic        frame_start,
`endif
    output logic [15:0] morph_data,
    output logic        morph_1bit,
    output logic        morph_wr_en
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;

    // Line buffers are deliberately not reset; border forcing hides stale contents.
    logic          lb0_q [IMG_W];
    logic          lb1_q [IMG_W];
    logic          tap0, tap1;

    // Window columns, oldest to newest; bit 2 = row r-2, bit 0 = row r.
    logic [2:0]    wc0_q, wc1_q, wc2_q;
    logic [CW-1:0] c1_q;
    logic [RW-1:0] r1_q;
    logic          v1_q;

    logic [8:0]    win;
    logic          border;
    logic          result;

    // Beat tag: current counters, optionally zeroed by a same-cycle frame_start.
    always_comb begin
        col_cur = col_q;
        row_cur = row_q;
`ifdef MORPH_FRAME_SYNC_EN
        if (frame_start) begin
            col_cur = '0;
            row_cur = '0;
        end
`endif
    end

    // Counter next-state; advance only on accepted beats.
    always_comb begin
        col_d = col_cur;
        row_d = row_cur;
        if (wr_en) begin
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign tap0 = lb0_q[col_cur];
    assign tap1 = lb1_q[col_cur];

    // Line buffer update; the reads above see the pre-write contents.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            lb1_q[col_cur] <= lb0_q[col_cur];
            lb0_q[col_cur] <= bin_in;
        end
    end

    // Stage 1: shift the window and carry the beat tag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wc0_q <= '0;
            wc1_q <= '0;
            wc2_q <= '0;
            c1_q  <= '0;
            r1_q  <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= wr_en;
            if (wr_en) begin
                wc0_q <= wc1_q;
                wc1_q <= wc2_q;
                wc2_q <= {tap1, tap0, bin_in};
                c1_q  <= col_cur;
                r1_q  <= row_cur;
            end
        end
    end

    // Morphological reduction with border override.
    always_comb begin
        win    = {wc0_q, wc1_q, wc2_q};
        border = (32'(r1_q) < 32'd2) || (32'(c1_q) < 32'd2);
        result = MODE ? (|win) : (&win);
        if (border) begin
            result = BORDER_VAL;
        end
    end

    // Stage 2: register outputs; data holds when no beat is in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            morph_data  <= 16'h0000;
            morph_1bit  <= 1'b0;
            morph_wr_en <= 1'b0;
        end else begin
            morph_wr_en <= v1_q;
            if (v1_q) begin
                morph_1bit <= result;
                morph_data <= {16{result}};
            end
        end
    end

endmodule

// File: tb/tb_sobel_morph_filter.sv
// Directed bench for sobel_morph_filter on an 8x6 image. Two instances share the
// stimulus: A = erosion with border 1, B = dilation with border 0.
module tb_sobel_morph_filter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        wr_en;
    logic        bin_in;
`ifdef MORPH_FRAME_SYNC_EN
    logic        frame_start;
    bit          fs_first;
`endif
    logic [15:0] data_a, data_b;
    logic        bit_a, bit_b;
    logic        we_a, we_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          oa_bit[$];
    logic [15:0] oa_data[$];
    int          oa_cyc[$];
    bit          ob_bit[$];
    logic [15:0] ob_data[$];
    int          in_q[$];

    sobel_morph_filter #(.IMG_W(8), .IMG_H(6), .MODE(1'b0), .BORDER_VAL(1'b1)) dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wr_en       (wr_en),
        .bin_in      (bin_in),
`ifdef MORPH_FRAME_SYNC_EN
        .frame_start (frame_start),
`endif
        .morph_data  (data_a),
        .morph_1bit  (bit_a),
        .morph_wr_en (we_a)
    );

    sobel_morph_filter #(.IMG_W(8), .IMG_H(6), .MODE(1'b1), .BORDER_VAL(1'b0)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wr_en       (wr_en),
        .bin_in      (bin_in),
`ifdef MORPH_FRAME_SYNC_EN
        .frame_start (frame_start),
`endif
        .morph_data  (data_b),
        .morph_1bit  (bit_b),
        .morph_wr_en (we_b)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Capture output beats away from the active edge.
    always @(negedge sys_clk) begin
        if (we_a) begin
            oa_bit.push_back(bit_a);
            oa_data.push_back(data_a);
            oa_cyc.push_back(cyc);
        end
        if (we_b) begin
            ob_bit.push_back(bit_b);
            ob_data.push_back(data_b);
        end
    end

    // Input images: 1 all ones, 2 single zero at (2,3), 3 single one at (3,3), 5 all zeros.
    function automatic bit pix(input int scen, input int r, input int c);
        case (scen)
            1:       return 1'b1;
            2:       return !(r == 2 && c == 3);
            3:       return (r == 3 && c == 3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_a(input int scen, input int r, input int c);
        bit brd = (r < 2) || (c < 2);
        case (scen)
            1:       return 1'b1;
            2:       return !(r >= 2 && r <= 4 && c >= 3 && c <= 5);
            default: return brd;
        endcase
    endfunction

    function automatic bit exp_b(input int scen, input int r, input int c);
        bit brd = (r < 2) || (c < 2);
        case (scen)
            1, 2:    return !brd;
            3:       return (r >= 3 && r <= 5 && c >= 3 && c <= 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int scen, input bit gaps, input int nbeats, input bit drain);
        in_q.delete();
        for (int k = 0; k < nbeats; k++) begin
            @(negedge sys_clk);
            wr_en  = 1'b1;
            bin_in = pix(scen, k / 8, k % 8);
`ifdef MORPH_FRAME_SYNC_EN
            frame_start = fs_first && (k == 0);
`endif
            in_q.push_back(cyc);
            if (gaps) begin
                @(negedge sys_clk);
                wr_en  = 1'b0;
                bin_in = 1'b0;
`ifdef MORPH_FRAME_SYNC_EN
                frame_start = 1'b0;
`endif
            end
        end
        if (drain) begin
            @(negedge sys_clk);
            wr_en  = 1'b0;
            bin_in = 1'b0;
`ifdef MORPH_FRAME_SYNC_EN
            frame_start = 1'b0;
`endif
            repeat (4) @(negedge sys_clk);
        end
    endtask

    task automatic check_frame(input int scen, input int base_a, input int base_b,
                               input string name);
        int na = oa_bit.size() - base_a;
        int nb = ob_bit.size() - base_b;
        chk($sformatf("%s count_a", name), na, 48);
        chk($sformatf("%s count_b", name), nb, 48);
        for (int k = 0; k < 48; k++) begin
            int r = k / 8;
            int c = k % 8;
            if (k < na) begin
                chk($sformatf("%s a_bit(%0d,%0d)", name, r, c),
                    32'(oa_bit[base_a + k]), 32'(exp_a(scen, r, c)));
                chk($sformatf("%s a_data(%0d,%0d)", name, r, c),
                    32'(oa_data[base_a + k]), 32'({16{exp_a(scen, r, c)}}));
                chk($sformatf("%s latency(%0d,%0d)", name, r, c),
                    oa_cyc[base_a + k], in_q[k] + 2);
            end
            if (k < nb) begin
                chk($sformatf("%s b_bit(%0d,%0d)", name, r, c),
                    32'(ob_bit[base_b + k]), 32'(exp_b(scen, r, c)));
                chk($sformatf("%s b_data(%0d,%0d)", name, r, c),
                    32'(ob_data[base_b + k]), 32'({16{exp_b(scen, r, c)}}));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ba, bb;
        sys_rst_n = 1'b0;
        wr_en     = 1'b0;
        bin_in    = 1'b0;
`ifdef MORPH_FRAME_SYNC_EN
        frame_start = 1'b0;
        fs_first    = 1'b0;
`endif
        repeat (2) @(negedge sys_clk);
        chk("reset a_data", 32'(data_a), 32'h0);
        chk("reset a_bit", 32'(bit_a), 32'h0);
        chk("reset a_we", 32'(we_a), 32'h0);
        chk("reset b_we", 32'(we_b), 32'h0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // All-ones frame.
        ba = oa_bit.size(); bb = ob_bit.size();
        send(1, 1'b0, 48, 1'b1);
        check_frame(1, ba, bb, "s1");

        // Single zero pixel at (2,3).
        ba = oa_bit.size(); bb = ob_bit.size();
        send(2, 1'b0, 48, 1'b1);
        check_frame(2, ba, bb, "s2");

        // Single one pixel at (3,3).
        ba = oa_bit.size(); bb = ob_bit.size();
        send(3, 1'b0, 48, 1'b1);
        check_frame(3, ba, bb, "s3");

        // Scenario 2 data with an idle cycle after each beat.
        ba = oa_bit.size(); bb = ob_bit.size();
        send(2, 1'b1, 48, 1'b1);
        check_frame(2, ba, bb, "s4");

`ifdef MORPH_FRAME_SYNC_EN
        // Run into mid-frame (next beat would be (3,5)), then realign with frame_start.
        ba = oa_bit.size() + 29; bb = ob_bit.size() + 29;
        send(1, 1'b0, 29, 1'b0);
        fs_first = 1'b1;
        send(2, 1'b0, 48, 1'b1);
        fs_first = 1'b0;
        check_frame(2, ba, bb, "s6");
`endif

        // Reset in mid-frame after beat 20, then an all-zero frame.
        send(2, 1'b0, 21, 1'b0);
        @(negedge sys_clk);
        wr_en     = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        chk("s5 post-reset a_data", 32'(data_a), 32'h0);
        chk("s5 post-reset a_bit", 32'(bit_a), 32'h0);
        chk("s5 post-reset a_we", 32'(we_a), 32'h0);
        @(negedge sys_clk);
        ba = oa_bit.size(); bb = ob_bit.size();
        send(5, 1'b0, 48, 1'b1);
        check_frame(5, ba, bb, "s5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
